// File: rtl/gpu_pkg.sv
// Shared screen geometry, widths, FSM encoding and the framebuffer write entry.
package gpu_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;
  localparam int ADDR_BITS    = 19;
  localparam int DATA_BITS    = 3 * CHANNEL_BITS;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } wr_ent_t;

  // y*w + x as a sum of shifted copies of y, one per set bit of the constant w
  // (640 -> (y<<9) + (y<<7) + x). w is always a parameter, so this folds to adders.
  function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [WIDTH_BITS-1:0]  x,
                                                     input logic [HEIGHT_BITS-1:0] y,
                                                     input int                     w);
    logic [ADDR_BITS-1:0] acc;
    logic [ADDR_BITS-1:0] ye;
    ye  = {{(ADDR_BITS-HEIGHT_BITS){1'b0}}, y};
    acc = {{(ADDR_BITS-WIDTH_BITS){1'b0}}, x};
    for (int i = 0; i < ADDR_BITS; i++) begin
      if (w[i]) acc = acc + (ye << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Single-clock FIFO; push and pop in the same cycle both take effect.
module gpu_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         last_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == (AW+1)'(1));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Pixel writer: clips incoming pixels, queues {addr,data} and drains them to the
// framebuffer SRAM with a we/ack handshake, one write per cycle when acked.
module gpu_pixel_writer #(
  parameter int WIDTH      = gpu_pkg::WIDTH,
  parameter int HEIGHT     = gpu_pkg::HEIGHT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid_i,
  output logic                             pix_ready_o,
  input  logic [gpu_pkg::WIDTH_BITS-1:0]   x_i,
  input  logic [gpu_pkg::HEIGHT_BITS-1:0]  y_i,
  input  logic [gpu_pkg::CHANNEL_BITS-1:0] r_i,
  input  logic [gpu_pkg::CHANNEL_BITS-1:0] g_i,
  input  logic [gpu_pkg::CHANNEL_BITS-1:0] b_i,
  output logic [gpu_pkg::ADDR_BITS-1:0]    mem_addr_o,
  output logic [gpu_pkg::DATA_BITS-1:0]    mem_data_o,
  output logic                             mem_we_o,
  input  logic                             mem_ack_i,
  output logic [15:0]                      clip_cnt_o,
  output logic                             idle_o
);

  import gpu_pkg::state_t;
  import gpu_pkg::ST_IDLE;
  import gpu_pkg::ST_WRITE;
  import gpu_pkg::wr_ent_t;
  import gpu_pkg::pix_addr;

  state_t      state_q, state_d;
  logic [15:0] clip_q, clip_d;
  wr_ent_t     push_ent, head_ent;
  logic        fifo_full, fifo_empty, fifo_last;
  logic        accept, in_range, push, pop;

  // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
  assign pix_ready_o   = !fifo_full;
  assign accept        = pix_valid_i && pix_ready_o;
  assign in_range      = (int'(x_i) < WIDTH) && (int'(y_i) < HEIGHT);
  assign push          = accept && in_range;
  assign pop           = (state_q == ST_WRITE) && mem_ack_i;
  assign push_ent.addr = pix_addr(x_i, y_i, WIDTH);
  assign push_ent.data = {r_i, g_i, b_i};

  gpu_sync_fifo #(
    .W     ($bits(wr_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_ent),
    .pop_i   (pop),
    .rdata_o (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  // State register; async reset drops mem_we_o immediately, aborting a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave WRITE only when the acked entry was the last and nothing arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_WRITE;
      ST_WRITE: if (mem_ack_i && fifo_last && !push) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: present the FIFO head while writing, zeros otherwise.
  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (state_q == ST_WRITE) begin
      mem_we_o   = 1'b1;
      mem_addr_o = head_ent.addr;
      mem_data_o = head_ent.data;
    end
  end

  // Clip counter next value, saturating at all-ones.
  always_comb begin
    clip_d = clip_q;
    if (accept && !in_range && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
  end

  // Clip counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clip_q <= '0;
    else     clip_q <= clip_d;
  end

  assign clip_cnt_o = clip_q;
  assign idle_o     = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Scoreboard bench: stimulus pushes expected writes, monitor pops on each acked write.
module tb_gpu_pixel_writer;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [9:0]  x_i = '0;
  logic [8:0]  y_i = '0;
  logic [7:0]  r_i = '0, g_i = '0, b_i = '0;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        mem_we_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] clip_cnt_o;
  logic        idle_o;

  gpu_pixel_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .x_i(x_i), .y_i(y_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_ack_i(mem_ack_i), .clip_cnt_o(clip_cnt_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; } exp_t;
  exp_t exp_q[$];
  int   exp_clip = 0;
  int   total = 0, bad = 0;
  int   nwrites = 0, last_addr = -1, last_data = -1;
  int   wr_cyc[$];
  int   ack_mode = 0;  // 0 never, 1 always, 2 random, 3 one cycle after we rises

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: frame is row-major, WIDTH words per row; anything off-screen is counted.
  function automatic void model_accept(input int x, input int y, input int r, input int g, input int b);
    exp_t e;
    if (x < W && y < H) begin
      e.addr = y * W + x;
      e.data = r * 65536 + g * 256 + b;
      exp_q.push_back(e);
    end else if (exp_clip < 65535) begin
      exp_clip++;
    end
  endfunction

  // SRAM ack responder
  initial begin : ack_drv
    bit we_prev;
    we_prev = 1'b0;
    forever begin
      @(negedge clk);
      case (ack_mode)
        0:       mem_ack_i = 1'b0;
        1:       mem_ack_i = 1'b1;
        2:       mem_ack_i = ($urandom_range(0, 2) != 0);
        default: mem_ack_i = we_prev && !mem_ack_i;
      endcase
      we_prev = mem_we_o;
    end
  end

  // Monitor: compares each accepted write, and checks stability while stalled
  initial begin : mon
    exp_t e;
    int   st_a, st_d;
    bit   stalled;
    stalled = 1'b0;
    st_a = 0;
    st_d = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_we", int'(mem_we_o), 1);
          check("hold_addr", int'(mem_addr_o), st_a);
          check("hold_data", int'(mem_data_o), st_d);
        end
        if (mem_we_o && mem_ack_i) begin
          nwrites++;
          wr_cyc.push_back(cyc);
          last_addr = int'(mem_addr_o);
          last_data = int'(mem_data_o);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wr_unexpected: got addr %0d want no write", last_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", last_addr, e.addr);
            check("wr_data", last_data, e.data);
          end
          stalled = 1'b0;
        end else if (mem_we_o) begin
          stalled = 1'b1;
          st_a = int'(mem_addr_o);
          st_d = int'(mem_data_o);
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // One cycle of offering a pixel; acc tells whether it transfers at the next edge
  task automatic offer(input int x, input int y, input int r, input int g, input int b, output bit acc);
    @(negedge clk);
    pix_valid_i = 1'b1;
    x_i = x[9:0];
    y_i = y[8:0];
    r_i = r[7:0];
    g_i = g[7:0];
    b_i = b[7:0];
    #1;
    acc = pix_ready_o;
    if (acc) model_accept(x, y, r, g, b);
  endtask

  task automatic send(input int x, input int y, input int r, input int g, input int b);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) offer(x, y, r, g, b, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    pix_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      #2;
      done = idle_o && (exp_q.size() == 0);
    end
    check(name, int'(idle_o), 1);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n0, base, nacc;
    bit  acc;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_idle", int'(idle_o), 1);
    check("rst_ready", int'(pix_ready_o), 1);
    check("rst_we", int'(mem_we_o), 0);
    check("rst_addr", int'(mem_addr_o), 0);
    check("rst_data", int'(mem_data_o), 0);
    check("rst_clip", int'(clip_cnt_o), 0);

    // single pixel, ack one cycle after we
    ack_mode = 3;
    n0 = nwrites;
    send(3, 2, 'h11, 'h22, 'h33);
    idle_bus();
    wait_drain("single_drain");
    check("single_count", nwrites - n0, 1);
    check("single_addr", last_addr, 1283);
    check("single_data", last_data, 'h112233);

    // backpressure: FIFO of 4 fills while ack held low
    ack_mode = 0;
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      offer(10 + i, 5, i, i + 1, i + 2, acc);
      if (acc) nacc++;
    end
    check("bp_accepted", nacc, 4);
    offer(20, 6, 'hAA, 'hBB, 'hCC, acc);
    check("bp_ready5", int'(acc), 0);
    ack_mode = 1;
    n0 = nwrites;
    base = wr_cyc.size();
    if (!acc) send(20, 6, 'hAA, 'hBB, 'hCC);
    idle_bus();
    wait_drain("bp_drain");
    check("bp_writes", nwrites - n0, 5);
    if (wr_cyc.size() >= base + 5) check("bp_back2back", wr_cyc[base + 4] - wr_cyc[base], 4);
    else check("bp_back2back", wr_cyc.size() - base, 5);

    // clipping on each axis boundary
    n0 = nwrites;
    send(640, 0, 1, 2, 3);
    send(0, 480, 4, 5, 6);
    idle_bus();
    repeat (5) @(negedge clk);
    #2;
    check("clip_cnt", int'(clip_cnt_o), exp_clip);
    check("clip_cnt_two", exp_clip, 2);
    check("clip_nowrite", nwrites - n0, 0);

    // far corner
    send(639, 479, 'hFF, 'h00, 'h7F);
    idle_bus();
    wait_drain("corner_drain");
    check("corner_addr", last_addr, 307199);

    // randomized traffic with random ack and gaps
    ack_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 767), $urandom_range(0, 511),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        idle_bus();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle_bus();
    wait_drain("rand_drain");
    check("rand_clip", int'(clip_cnt_o), exp_clip);

    // reset in the middle of a stalled write with three queued
    ack_mode = 0;
    for (int i = 0; i < 3; i++) send(100 + i, 7, i, i, i);
    idle_bus();
    repeat (2) @(negedge clk);
    #2;
    check("abort_pre_we", int'(mem_we_o), 1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_we_low", int'(mem_we_o), 0);
    exp_q.delete();
    exp_clip = 0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    ack_mode = 1;
    n0 = nwrites;
    repeat (10) @(negedge clk);
    #2;
    check("abort_idle", int'(idle_o), 1);
    check("abort_nowrite", nwrites - n0, 0);
    check("abort_ready", int'(pix_ready_o), 1);
    check("abort_clip", int'(clip_cnt_o), 0);
    check("abort_addr", int'(mem_addr_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_pixel_writer.md
GPU_PIXEL_WRITER -- requirements
Module: gpu_pixel_writer

Interface
REQ-001 Parameter WIDTH, default 640, screen width in pixels.
REQ-002 Parameter HEIGHT, default 480, screen height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, pixel FIFO entries (power of two).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 pix_valid_i  in  1  pixel present on x_i/y_i/r_i/g_i/b_i.
REQ-007 pix_ready_o  out  1  writer accepts a pixel this cycle.
REQ-008 x_i  in  WIDTH_BITS (10)  pixel column.
REQ-009 y_i  in  HEIGHT_BITS (9)  pixel row.
REQ-010 r_i, g_i, b_i  in  CHANNEL_BITS (8) each  pixel colour.
REQ-011 mem_addr_o  out  ADDR_BITS (19)  framebuffer word address.
REQ-012 mem_data_o  out  24  packed colour {r,g,b}, r in bits 23:16.
REQ-013 mem_we_o  out  1  write request to framebuffer SRAM.
REQ-014 mem_ack_i  in  1  SRAM accepted the current write.
REQ-015 clip_cnt_o  out  16  count of dropped out-of-range pixels.
REQ-016 idle_o  out  1  FIFO empty and no write outstanding.

Function
REQ-017 Pixel transfer occurs on a cycle with pix_valid_i=1 and pix_ready_o=1.
REQ-018 pix_ready_o = FIFO not full; a pop in the same cycle does not raise pix_ready_o.
REQ-019 Accepted pixel with x_i>=WIDTH or y_i>=HEIGHT is dropped (no FIFO push) and clip_cnt_o increments.
REQ-020 clip_cnt_o saturates at 16'hFFFF.
REQ-021 In-range pixel is pushed as {addr, data}; addr = y_i*WIDTH + x_i computed at push time, 19-bit, no truncation for valid coordinates.
REQ-022 FSM states IDLE, WRITE.
REQ-023 IDLE -> WRITE on the cycle after FIFO becomes non-empty; mem_we_o=1, mem_addr_o/mem_data_o driven from FIFO head.
REQ-024 In WRITE, addr/data/we held stable until mem_ack_i=1.
REQ-025 Cycle with mem_ack_i=1 in WRITE pops the FIFO head; if another entry remains, stay in WRITE and present it next cycle (back-to-back, one write per cycle at full rate); else -> IDLE with mem_we_o=0 next cycle.
REQ-026 mem_ack_i ignored in IDLE.
REQ-027 Push and pop in the same cycle both take effect; occupancy unchanged.
REQ-028 Writes issue in acceptance order; no reordering, no merging.
REQ-029 idle_o = 1 exactly when state is IDLE and FIFO empty.
REQ-030 mem_addr_o/mem_data_o are don't-care when mem_we_o=0 but driven to 0 after reset.

Reset
REQ-031 On rst=1: state IDLE, FIFO emptied, mem_we_o=0, mem_addr_o=0, mem_data_o=0, clip_cnt_o=0, idle_o=1, pix_ready_o=1 (after release).
REQ-032 rst mid-write aborts the write immediately (mem_we_o low asynchronously); pending pixels are discarded.

Structure
REQ-033 WIDTH, HEIGHT, WIDTH_BITS, HEIGHT_BITS, CHANNEL_BITS, ADDR_BITS and the FSM state enum live in shared package gpu_pkg.
REQ-034 FIFO is sub-module gpu_sync_fifo (parameterised width/depth, full/empty, same-cycle push/pop).
REQ-035 Address multiply implemented as shift-add (y<<9 + y<<7 + x for WIDTH=640).

Verification
REQ-036 Single pixel x=3,y=2,rgb=11/22/33, ack 1 cycle after we -> addr 1283, data 24'h112233, one write, idle_o returns 1.
REQ-037 Five pixels back-to-back, mem_ack_i held low -> 4 accepted, pix_ready_o=0 on 5th; release ack -> 5 writes in order, one per cycle.
REQ-038 Pixel x=640,y=0 and x=0,y=480 -> no write, clip_cnt_o=2.
REQ-039 Corner x=639,y=479 -> addr 307199.
REQ-040 rst asserted during WRITE with 3 queued -> mem_we_o=0 same cycle, after release idle_o=1, no further writes.
